// File: rtl/spi_ram_pkg.sv
// Shared command encodings and pointer mode type for the SPI-attached burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    PTR_HOLD   = 1'b0,
    PTR_STREAM = 1'b1
  } ptr_mode_t;

endpackage

// File: rtl/ram_addr_ptr.sv
// Address pointer with range-checked load and wrap-at-depth auto-increment.
// The HOLD/STREAM mode of the most recent data access is kept as visible state.
module ram_addr_ptr
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 access,
  input  logic                 stream,
  output logic [ADDR_SIZE-1:0] ptr,
  output logic                 load_err,
  output logic                 mode
);

  localparam logic [ADDR_SIZE:0]   DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);

  ptr_mode_t state;
  logic      addr_ok;

  // Extra leading zero keeps the compare meaningful when MEM_DEPTH == 2**ADDR_SIZE.
  assign addr_ok  = {1'b0, addr} < DEPTH_W;
  assign load_err = load & ~addr_ok;
  assign mode     = (state == PTR_STREAM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      state <= PTR_HOLD;
    end else if (load) begin
      if (addr_ok) ptr <= addr;
    end else if (access) begin
      state <= stream ? PTR_STREAM : PTR_HOLD;
      if (stream) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_burst_ram.sv
// Single-port RAM behind an SPI slave: command decode, burst pointers, one-deep
// read output slot with valid/ready handoff, and a registered illegal-command pulse.
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  burst_en,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  cmd_err,
  output logic [1:0]            dbg_ptr_mode
);

  // Handshake: dout is offered while tx_valid=1 and is consumed in any cycle
  // where tx_valid=1 and tx_ready=1; dout/tx_valid never change while offered
  // and unconsumed. A read can refill the slot in the cycle it is consumed.

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] addr;
  logic                 is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;
  logic                 slot_free, rd_accept, rd_reject;
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic                 wr_load_err, rd_load_err;
  logic                 wr_mode, rd_mode;

  assign cmd  = din[DATA_WIDTH+1:DATA_WIDTH];
  assign addr = din[ADDR_SIZE-1:0];

  assign is_wr_addr = rx_valid & (cmd == CMD_WR_ADDR);
  assign is_wr_data = rx_valid & (cmd == CMD_WR_DATA);
  assign is_rd_addr = rx_valid & (cmd == CMD_RD_ADDR);
  assign is_rd_data = rx_valid & (cmd == CMD_RD_DATA);

  assign slot_free = ~tx_valid | tx_ready;
  assign rd_accept = is_rd_data & slot_free;
  assign rd_reject = is_rd_data & ~slot_free;

  assign dbg_ptr_mode = {rd_mode, wr_mode};

  ram_addr_ptr #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_wr_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (is_wr_addr),
    .addr     (addr),
    .access   (is_wr_data),
    .stream   (burst_en),
    .ptr      (wr_ptr),
    .load_err (wr_load_err),
    .mode     (wr_mode)
  );

  ram_addr_ptr #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_rd_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (is_rd_addr),
    .addr     (addr),
    .access   (rd_accept),
    .stream   (burst_en),
    .ptr      (rd_ptr),
    .load_err (rd_load_err),
    .mode     (rd_mode)
  );

  // Contents survive reset; only writes are suppressed while it is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && is_wr_data) mem[wr_ptr] <= din[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      dout     <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= wr_load_err | rd_load_err | rd_reject;
      if (rd_accept) begin
        dout     <= mem[rd_ptr];
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram at MEM_DEPTH=200 with hand-computed expectations.
module tb_spi_burst_ram;

  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int DW    = 8;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          rx_valid;
  logic [DW+1:0] din;
  logic          burst_en;
  logic          tx_ready;
  logic          tx_valid;
  logic [DW-1:0] dout;
  logic          cmd_err;
  logic [1:0]    dbg_ptr_mode;

  int n_checks;
  int n_errors;
  logic [DW-1:0] exp_q[$];

  spi_burst_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .din          (din),
    .burst_en     (burst_en),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .dout         (dout),
    .cmd_err      (cmd_err),
    .dbg_ptr_mode (dbg_ptr_mode)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p, input logic b);
    din      = {c, p};
    burst_en = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    burst_en = 1'b0;
  endtask

  initial begin
    logic       err_seen;
    logic [7:0] got_b;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = '0;
    burst_en = 1'b0;
    tx_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // preload mem[i] = i % 32 through a burst write
    send(WA, 8'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(WD, 8'(i % 32), 1'b1);
    check("preload_wr_ptr_wrapped", 32'(dut.wr_ptr), 32'd0);

    // 1: reset with a pending, unconsumed output
    tx_ready = 1'b0;
    send(RA, 8'd40, 1'b0);
    send(RD, 8'h00, 1'b0);
    check("t1_pending_valid", 32'(tx_valid), 32'd1);
    check("t1_pending_dout", 32'(dout), 32'd8);
    send(RD, 8'h00, 1'b0);
    check("t1_reject_err", 32'(cmd_err), 32'd1);
    rst_n = 1'b0;
    step();
    check("t1_rst_valid", 32'(tx_valid), 32'd0);
    check("t1_rst_dout", 32'(dout), 32'd0);
    check("t1_rst_err", 32'(cmd_err), 32'd0);
    check("t1_rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    check("t1_rst_mode", 32'(dbg_ptr_mode), 32'd0);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    send(RA, 8'd30, 1'b0);
    exp_q = '{8'd30, 8'd31, 8'd0};
    for (int i = 0; i < 3; i++) begin
      send(RD, 8'h00, 1'b1);
      got_b = exp_q.pop_front();
      check($sformatf("t1_mem_kept_%0d", i), 32'(dout), 32'(got_b));
    end
    check("t1_mem31", 32'(dut.mem[31]), 32'd31);
    check("t1_mem32", 32'(dut.mem[32]), 32'd0);

    // 2: single write and read, one-cycle latency then slot drains
    send(WA, 8'h10, 1'b0);
    send(WD, 8'hA5, 1'b0);
    check("t2_wr_ptr_hold", 32'(dut.wr_ptr), 32'h10);
    send(RA, 8'h10, 1'b0);
    send(RD, 8'h00, 1'b0);
    check("t2_valid", 32'(tx_valid), 32'd1);
    check("t2_dout", 32'(dout), 32'hA5);
    check("t2_rd_ptr_hold", 32'(dut.rd_ptr), 32'h10);
    step();
    check("t2_drained", 32'(tx_valid), 32'd0);
    check("t2_dout_held", 32'(dout), 32'hA5);

    // 3: burst wraps at depth 200
    send(WA, 8'd198, 1'b0);
    send(WD, 8'd1, 1'b1);
    send(WD, 8'd2, 1'b1);
    send(WD, 8'd3, 1'b1);
    check("t3_wr_ptr", 32'(dut.wr_ptr), 32'd1);
    check("t3_mem0", 32'(dut.mem[0]), 32'd3);
    send(RA, 8'd198, 1'b0);
    exp_q = '{8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 3; i++) begin
      send(RD, 8'h00, 1'b1);
      got_b = exp_q.pop_front();
      check($sformatf("t3_burst_rd_%0d", i), 32'(dout), 32'(got_b));
    end
    check("t3_rd_ptr", 32'(dut.rd_ptr), 32'd1);
    check("t3_mode_stream", 32'(dbg_ptr_mode), 32'd3);

    // 4: out-of-range pointer loads
    send(WA, 8'h20, 1'b0);
    check("t4_ok_no_err", 32'(cmd_err), 32'd0);
    send(WA, 8'hF0, 1'b0);
    check("t4_err", 32'(cmd_err), 32'd1);
    check("t4_wr_ptr_kept", 32'(dut.wr_ptr), 32'h20);
    send(WD, 8'h77, 1'b0);
    check("t4_err_pulse_end", 32'(cmd_err), 32'd0);
    send(RA, 8'd200, 1'b0);
    check("t4_rd_200_err", 32'(cmd_err), 32'd1);
    send(RA, 8'd199, 1'b0);
    check("t4_rd_199_ok", 32'(cmd_err), 32'd0);
    check("t4_rd_ptr_199", 32'(dut.rd_ptr), 32'd199);
    send(RA, 8'h20, 1'b0);
    send(RD, 8'h00, 1'b0);
    check("t4_landed", 32'(dout), 32'h77);
    step();

    // 5: backpressure
    tx_ready = 1'b0;
    send(RA, 8'h50, 1'b0);
    send(RD, 8'h00, 1'b1);
    check("t5_first", 32'(dout), 32'd16);
    send(RD, 8'h00, 1'b1);
    check("t5_reject_err", 32'(cmd_err), 32'd1);
    check("t5_dout_stable", 32'(dout), 32'd16);
    check("t5_rd_ptr_once", 32'(dut.rd_ptr), 32'h51);
    step();
    check("t5_valid_held", 32'(tx_valid), 32'd1);
    check("t5_err_cleared", 32'(cmd_err), 32'd0);
    tx_ready = 1'b1;
    send(RD, 8'h00, 1'b1);
    check("t5_refill_valid", 32'(tx_valid), 32'd1);
    check("t5_refill_dout", 32'(dout), 32'd17);
    check("t5_refill_no_err", 32'(cmd_err), 32'd0);
    step();
    check("t5_drain", 32'(tx_valid), 32'd0);
    check("t5_dout_kept", 32'(dout), 32'd17);

    // 6: idle with noise on din / burst_en
    err_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      din      = 10'($urandom_range(0, 1023));
      burst_en = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
      step();
      err_seen = err_seen | cmd_err | tx_valid;
    end
    burst_en = 1'b0;
    check("t6_no_activity", 32'(err_seen), 32'd0);
    check("t6_wr_ptr", 32'(dut.wr_ptr), 32'h20);
    check("t6_rd_ptr", 32'(dut.rd_ptr), 32'h52);
    check("t6_mem20", 32'(dut.mem[8'h20]), 32'h77);
    check("t6_mem198", 32'(dut.mem[198]), 32'd1);
    check("t6_mem_52", 32'(dut.mem[8'h52]), 32'd18);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
